// File: rtl/exec_core_pkg.sv
// Shared types for the execution core: opcodes, FSM states and flag bit positions.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_MUL = 3'd3,
        OP_MOV = 3'd4,
        OP_LDI = 3'd5,
        OP_LD  = 3'd6,
        OP_ST  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MUL  = 2'd2
    } st_e;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/exec_core_if.sv
// Instruction channel between a front end (switch decoder or sequencer) and the core.
interface exec_core_if #(
    parameter int DATA_W = 8,
    parameter int RW     = 2
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [RW-1:0]     instr_rd;
    logic [RW-1:0]     instr_ra;
    logic [RW-1:0]     instr_rb;
    logic [DATA_W-1:0] instr_imm;
    logic              done;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        input  instr_ready, done
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        output instr_ready, done
    );
endinterface

// File: rtl/exec_core_regfile_n.sv
// DATA_W x NREGS register file: two async operand reads, one debug read, one sync write.
module regfile_n #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 4,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_sel];
endmodule

// File: rtl/exec_core.sv
// Instruction-driven execution core: register file, ALU, shift-add multiplier,
// data memory and memory-mapped output register behind a valid/ready channel.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | accepting; single-cycle ops and stores complete at accept
//  ST_RD   | load address registered, memory word written back next edge
//  ST_MUL  | one shift-add iteration per cycle, writeback on last iteration
module exec_core
    import exec_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int NREGS     = 4,
    parameter  int MEM_DEPTH = 128,
    localparam int RW        = $clog2(NREGS),
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    exec_core_if.slave        ibus,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] out_reg,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int PW  = 2 * DATA_W;
    localparam int CW  = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;

    st_e               state;
    logic              done_q;
    logic [CW-1:0]     mul_cnt;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [DATA_W-1:0] mplier;
    logic [RW-1:0]     pend_rd;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    op_e               op;
    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   dif_ext;
    logic [PW-1:0]     acc_step;
    logic [DATA_W-1:0] res;
    logic              res_c;
    logic              res_v;
    logic              wb_en;
    logic [RW-1:0]     wb_addr;
    logic              flg_en;
    logic [3:0]        flg_next;

    assign op               = op_e'(ibus.instr_op);
    assign ibus.instr_ready = (state == ST_IDLE);
    assign accept           = ibus.instr_valid && (state == ST_IDLE);
    assign ibus.done        = done_q;

    regfile_n #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (res),
        .ra_addr  (ibus.instr_ra),
        .ra_data  (op_a),
        .rb_addr  (ibus.instr_rb),
        .rb_data  (op_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // Writeback source: ALU at accept, memory in RD, final accumulator step in MUL.
    always_comb begin
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        dif_ext  = {1'b0, op_a} - {1'b0, op_b};
        acc_step = mplier[0] ? (acc + mcand) : acc;
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = ibus.instr_rd;
        flg_en   = 1'b0;
        if (accept) begin
            case (op)
                OP_ADD: begin
                    res    = sum_ext[DATA_W-1:0];
                    res_c  = sum_ext[DATA_W];
                    res_v  = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
                    wb_en  = 1'b1;
                    flg_en = 1'b1;
                end
                OP_SUB: begin
                    res    = dif_ext[DATA_W-1:0];
                    res_c  = dif_ext[DATA_W];
                    res_v  = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
                    wb_en  = 1'b1;
                    flg_en = 1'b1;
                end
                OP_AND: begin
                    res    = op_a & op_b;
                    wb_en  = 1'b1;
                    flg_en = 1'b1;
                end
                OP_MOV: begin
                    res    = op_a;
                    wb_en  = 1'b1;
                end
                OP_LDI: begin
                    res    = ibus.instr_imm;
                    wb_en  = 1'b1;
                end
                default: ;
            endcase
        end else if (state == ST_RD) begin
            res     = mem[ld_addr];
            wb_en   = 1'b1;
            wb_addr = pend_rd;
        end else if (state == ST_MUL && mul_cnt == '0) begin
            res     = acc_step[DATA_W-1:0];
            res_c   = |acc_step[PW-1:DATA_W];
            res_v   = |acc_step[PW-1:DATA_W];
            wb_en   = 1'b1;
            wb_addr = pend_rd;
            flg_en  = 1'b1;
        end
        flg_next        = '0;
        flg_next[FLG_Z] = (res == '0);
        flg_next[FLG_N] = res[MSB];
        flg_next[FLG_C] = res_c;
        flg_next[FLG_V] = res_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            done_q  <= 1'b0;
            flags   <= '0;
            out_reg <= '0;
            mul_cnt <= '0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            pend_rd <= '0;
            ld_addr <= '0;
        end else begin
            done_q <= 1'b0;
            if (flg_en) begin
                flags <= flg_next;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pend_rd <= ibus.instr_rd;
                        case (op)
                            OP_LD: begin
                                ld_addr <= op_a[AW-1:0];
                                state   <= ST_RD;
                            end
                            OP_MUL: begin
                                mcand   <= PW'(op_a);
                                mplier  <= op_b;
                                acc     <= '0;
                                mul_cnt <= CW'(DATA_W - 1);
                                state   <= ST_MUL;
                            end
                            OP_ST: begin
                                if (op_a[MSB]) begin
                                    out_reg <= op_b;
                                end
                                done_q <= 1'b1;
                            end
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                ST_RD: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                end
                ST_MUL: begin
                    acc     <= acc_step;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt - CW'(1);
                    if (mul_cnt == '0) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (!reset && accept && op == OP_ST && !op_a[MSB]) begin
            mem[op_a[AW-1:0]] <= op_b;
        end
    end
endmodule

// File: tb/tb_exec_core.sv
// Bench for exec_core: directed scenarios plus random programs against an arithmetic model.
module tb_exec_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exec_core_if #(.DATA_W(8),  .RW(2)) if8 ();
    exec_core_if #(.DATA_W(16), .RW(3)) if16 ();

    logic [3:0]  flags8, flags16;
    logic [7:0]  out8, dbg8;
    logic [15:0] out16, dbg16;
    logic [1:0]  sel8 = '0;
    logic [2:0]  sel16 = '0;

    exec_core #(.DATA_W(8), .NREGS(4), .MEM_DEPTH(128)) u8 (
        .clk(clk), .reset(reset), .ibus(if8.slave), .flags(flags8),
        .out_reg(out8), .dbg_sel(sel8), .dbg_data(dbg8));

    exec_core #(.DATA_W(16), .NREGS(8), .MEM_DEPTH(128)) u16 (
        .clk(clk), .reset(reset), .ibus(if16.slave), .flags(flags16),
        .out_reg(out16), .dbg_sel(sel16), .dbg_data(dbg16));

    int checks = 0;
    int errors = 0;

    longint m_reg [2][8];
    longint m_mem [2][128];
    int     m_flags [2];
    longint m_out [2];

    function automatic int width_of(bit wd); return wd ? 16 : 8; endfunction
    function automatic int nregs(bit wd);    return wd ? 8 : 4;   endfunction
    function automatic int exp_lat(bit wd, int op);
        return (op == 3) ? width_of(wd) + 1 : (op == 6) ? 2 : 1;
    endfunction
    function automatic int exp_busy(bit wd, int op);
        return (op == 3) ? width_of(wd) : (op == 6) ? 1 : 0;
    endfunction
    function automatic bit rdy(bit wd); return wd ? if16.instr_ready : if8.instr_ready; endfunction
    function automatic bit dn(bit wd);  return wd ? if16.done : if8.done; endfunction
    function automatic int dut_flags(bit wd); return wd ? int'(flags16) : int'(flags8); endfunction
    function automatic longint dut_out(bit wd); return wd ? longint'(out16) : longint'(out8); endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 8; r++) m_reg[d][r] = 0;
            m_flags[d] = 0;
            m_out[d] = 0;
        end
    endfunction

    // Architectural effect of one instruction, from the ISA rules in plain arithmetic.
    function automatic void model_apply(bit wd, int op, int rd, int ra, int rb, longint imm);
        int w;
        longint modv, half, a, b, sa, sb, ss, full, res;
        bit c, v, upd;
        w = width_of(wd);
        modv = longint'(1) << w;
        half = longint'(1) << (w - 1);
        a = m_reg[wd][ra];
        b = m_reg[wd][rb];
        sa = (a >= half) ? a - modv : a;
        sb = (b >= half) ? b - modv : b;
        c = 0; v = 0; upd = 0; res = 0;
        case (op)
            0: begin full = a + b; res = full % modv; c = full >= modv;
                     ss = sa + sb; v = (ss >= half) || (ss < -half); upd = 1; end
            1: begin res = (a - b + modv) % modv; c = a < b;
                     ss = sa - sb; v = (ss >= half) || (ss < -half); upd = 1; end
            2: begin res = a & b; upd = 1; end
            3: begin full = a * b; res = full % modv; c = full >= modv; v = c; upd = 1; end
            4: res = a;
            5: res = imm % modv;
            6: res = m_mem[wd][a % 128];
            default: begin
                if (a >= half) m_out[wd] = b;
                else m_mem[wd][a % 128] = b;
            end
        endcase
        if (op != 7) m_reg[wd][rd] = res;
        if (upd) m_flags[wd] = ((res == 0) ? 8 : 0) | ((res >= half) ? 4 : 0) | (c ? 2 : 0) | (v ? 1 : 0);
    endfunction

    task automatic drive(input bit wd, input bit vld, input int op, input int rd, input int ra,
                         input int rb, input longint imm);
        if (wd) begin
            if16.instr_valid = vld; if16.instr_op = 3'(op); if16.instr_rd = 3'(rd);
            if16.instr_ra = 3'(ra); if16.instr_rb = 3'(rb); if16.instr_imm = 16'(imm);
        end else begin
            if8.instr_valid = vld; if8.instr_op = 3'(op); if8.instr_rd = 2'(rd);
            if8.instr_ra = 2'(ra); if8.instr_rb = 2'(rb); if8.instr_imm = 8'(imm);
        end
    endtask

    task automatic read_reg(input bit wd, input int r, output longint val);
        if (wd) sel16 = 3'(r); else sel8 = 2'(r);
        #1;
        val = wd ? longint'(dbg16) : longint'(dbg8);
    endtask

    // Issue one instruction, then measure cycles to done and cycles with ready low.
    task automatic issue(input bit wd, input int op, input int rd, input int ra, input int rb,
                         input longint imm, output int lat, output int busy, output bit again);
        int k;
        drive(wd, 1'b1, op, rd, ra, rb, imm);
        k = 0;
        while (!rdy(wd) && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        model_apply(wd, op, rd, ra, rb, imm);
        @(negedge clk);
        drive(wd, 1'b0, op, rd, ra, rb, imm);
        lat = -1;
        busy = 0;
        for (int j = 1; j <= 50; j++) begin
            if (dn(wd)) begin lat = j; break; end
            if (!rdy(wd)) busy++;
            @(negedge clk);
        end
        @(negedge clk);
        again = dn(wd);
    endtask

    task automatic test_reset();
        longint val;
        checks++; if (if8.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", if8.instr_ready); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", if8.done); end
        checks++; if (flags8 !== 4'h0) begin errors++; $display("FAIL reset_flags got %h want 0", flags8); end
        checks++; if (out8 !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 0", out8); end
        checks++; if (if16.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready16 got %0b want 1", if16.instr_ready); end
        for (int r = 0; r < 4; r++) begin
            read_reg(0, r, val);
            checks++; if (val != 0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", r, val); end
        end
    endtask

    task automatic test_alu_basic();
        int lat, busy, nrdy; bit again; longint val;
        nrdy = 0;
        issue(0, 5, 1, 0, 0, 8'h05, lat, busy, again); nrdy += busy;
        checks++; if (lat != 1) begin errors++; $display("FAIL ldi_latency got %0d want 1", lat); end
        issue(0, 5, 2, 0, 0, 8'h03, lat, busy, again); nrdy += busy;
        issue(0, 0, 0, 1, 2, 0, lat, busy, again); nrdy += busy;
        checks++; if (lat != 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (again !== 1'b0) begin errors++; $display("FAIL add_done_width got %0b want 0", again); end
        checks++; if (nrdy != 0) begin errors++; $display("FAIL alu_ready_drop got %0d want 0", nrdy); end
        read_reg(0, 0, val);
        checks++; if (val != 8'h08) begin errors++; $display("FAIL add_result got %h want 08", val); end
        checks++; if (flags8 !== 4'b0000) begin errors++; $display("FAIL add_flags got %b want 0000", flags8); end
        issue(0, 1, 3, 2, 1, 0, lat, busy, again);
        read_reg(0, 3, val);
        checks++; if (val != 8'hFE) begin errors++; $display("FAIL sub_result got %h want fe", val); end
        checks++; if (flags8 !== 4'b0110) begin errors++; $display("FAIL sub_flags got %b want 0110", flags8); end
        issue(0, 5, 3, 0, 0, 8'h7F, lat, busy, again);
        checks++; if (flags8 !== 4'b0110) begin errors++; $display("FAIL ldi_holds_flags got %b want 0110", flags8); end
        issue(0, 0, 3, 3, 3, 0, lat, busy, again);
        read_reg(0, 3, val);
        checks++; if (val != 8'hFE) begin errors++; $display("FAIL add_ovf_result got %h want fe", val); end
        checks++; if (flags8 !== 4'b0101) begin errors++; $display("FAIL add_ovf_flags got %b want 0101", flags8); end
    endtask

    task automatic test_back_to_back();
        int ops [5] = '{0, 1, 2, 4, 5};
        int op, rd, ra, rb; longint imm, val;
        for (int i = 0; i < 8; i++) begin
            op = ops[$urandom_range(0, 4)];
            rd = $urandom_range(0, 3); ra = $urandom_range(0, 3); rb = $urandom_range(0, 3);
            imm = $urandom_range(0, 255);
            drive(0, 1'b1, op, rd, ra, rb, imm);
            @(posedge clk);
            model_apply(0, op, rd, ra, rb, imm);
            @(negedge clk);
            checks++; if (if8.done !== 1'b1 || if8.instr_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_done_ready step %0d got done=%0b ready=%0b want 1 1", i, if8.done, if8.instr_ready);
            end
        end
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            read_reg(0, r, val);
            checks++; if (val != m_reg[0][r]) begin errors++; $display("FAIL b2b_reg%0d got %h want %h", r, val, m_reg[0][r]); end
        end
        checks++; if (int'(flags8) != m_flags[0]) begin errors++; $display("FAIL b2b_flags got %b want %b", flags8, 4'(m_flags[0])); end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat, busy, done_at; bit again; longint val, r3_old;
        issue(0, 5, 1, 0, 0, 8'h10, lat, busy, again);
        issue(0, 5, 2, 0, 0, 8'h11, lat, busy, again);
        r3_old = m_reg[0][3];
        drive(0, 1'b1, 3, 0, 1, 2, 0);
        @(posedge clk);
        model_apply(0, 3, 0, 1, 2, 0);
        @(negedge clk);
        drive(0, 1'b1, 5, 3, 0, 0, 8'h77);
        busy = 0; done_at = -1;
        for (int k = 1; k <= 30; k++) begin
            if (if8.done && done_at < 0) done_at = k;
            if (if8.instr_ready) break;
            busy++;
            read_reg(0, 3, val);
            checks++; if (val != r3_old) begin errors++; $display("FAIL mul_held_accepted cycle %0d got %h want %h", k, val, r3_old); end
            @(negedge clk);
        end
        checks++; if (busy != 8) begin errors++; $display("FAIL mul_busy got %0d want 8", busy); end
        checks++; if (done_at != 9) begin errors++; $display("FAIL mul_done_cycle got %0d want 9", done_at); end
        read_reg(0, 0, val);
        checks++; if (val != 8'h10) begin errors++; $display("FAIL mul_result got %h want 10", val); end
        checks++; if (flags8 !== 4'b0011) begin errors++; $display("FAIL mul_flags got %b want 0011", flags8); end
        @(posedge clk);
        model_apply(0, 5, 3, 0, 0, 8'h77);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        checks++; if (if8.done !== 1'b1) begin errors++; $display("FAIL held_ldi_done got %0b want 1", if8.done); end
        read_reg(0, 3, val);
        checks++; if (val != 8'h77) begin errors++; $display("FAIL held_ldi_result got %h want 77", val); end
        @(negedge clk);
    endtask

    task automatic test_mem();
        int lat, busy; bit again; longint val;
        for (int a = 0; a < 128; a++) begin
            issue(0, 5, 1, 0, 0, a, lat, busy, again);
            issue(0, 5, 2, 0, 0, $urandom_range(0, 255), lat, busy, again);
            issue(0, 7, 0, 1, 2, 0, lat, busy, again);
        end
        issue(0, 5, 1, 0, 0, 8'h05, lat, busy, again);
        issue(0, 5, 2, 0, 0, 8'hA5, lat, busy, again);
        issue(0, 7, 0, 1, 2, 0, lat, busy, again);
        checks++; if (lat != 1) begin errors++; $display("FAIL st_latency got %0d want 1", lat); end
        issue(0, 6, 3, 1, 0, 0, lat, busy, again);
        checks++; if (lat != 2 || busy != 1) begin errors++; $display("FAIL ld_timing got lat=%0d busy=%0d want 2 1", lat, busy); end
        read_reg(0, 3, val);
        checks++; if (val != 8'hA5) begin errors++; $display("FAIL ld_result got %h want a5", val); end
        issue(0, 5, 0, 0, 0, 8'h00, lat, busy, again);
        issue(0, 5, 2, 0, 0, 8'h5A, lat, busy, again);
        issue(0, 7, 0, 0, 2, 0, lat, busy, again);
        issue(0, 5, 1, 0, 0, 8'h80, lat, busy, again);
        issue(0, 5, 2, 0, 0, 8'h3C, lat, busy, again);
        issue(0, 7, 0, 1, 2, 0, lat, busy, again);
        checks++; if (out8 !== 8'h3C) begin errors++; $display("FAIL st_out_reg got %h want 3c", out8); end
        issue(0, 6, 3, 0, 0, 0, lat, busy, again);
        read_reg(0, 3, val);
        checks++; if (val != 8'h5A) begin errors++; $display("FAIL st_out_mem0 got %h want 5a", val); end
    endtask

    task automatic test_random(input bit wd, input int n, input int max_op);
        int op, rd, ra, rb, lat, busy; bit again; longint val;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, max_op);
            rd = $urandom_range(0, nregs(wd) - 1);
            ra = $urandom_range(0, nregs(wd) - 1);
            rb = $urandom_range(0, nregs(wd) - 1);
            issue(wd, op, rd, ra, rb, $urandom, lat, busy, again);
            checks++; if (lat != exp_lat(wd, op) || busy != exp_busy(wd, op) || again !== 1'b0) begin
                errors++; $display("FAIL rnd_timing w%0d op%0d got lat=%0d busy=%0d again=%0b want %0d %0d 0",
                                   width_of(wd), op, lat, busy, again, exp_lat(wd, op), exp_busy(wd, op));
            end
            checks++; if (dut_flags(wd) != m_flags[wd]) begin
                errors++; $display("FAIL rnd_flags w%0d op%0d got %b want %b", width_of(wd), op, 4'(dut_flags(wd)), 4'(m_flags[wd]));
            end
            checks++; if (dut_out(wd) != m_out[wd]) begin
                errors++; $display("FAIL rnd_out w%0d got %h want %h", width_of(wd), dut_out(wd), m_out[wd]);
            end
            for (int r = 0; r < nregs(wd); r++) begin
                read_reg(wd, r, val);
                checks++; if (val != m_reg[wd][r]) begin
                    errors++; $display("FAIL rnd_reg w%0d op%0d r%0d got %h want %h", width_of(wd), op, r, val, m_reg[wd][r]);
                end
            end
        end
    endtask

    task automatic test_wide();
        int lat, busy; bit again; longint val;
        issue(1, 5, 1, 0, 0, 16'h00FF, lat, busy, again);
        issue(1, 5, 2, 0, 0, 16'h0101, lat, busy, again);
        issue(1, 3, 0, 1, 2, 0, lat, busy, again);
        checks++; if (lat != 17 || busy != 16) begin errors++; $display("FAIL mul16_timing got lat=%0d busy=%0d want 17 16", lat, busy); end
        read_reg(1, 0, val);
        checks++; if (val != 16'hFFFF) begin errors++; $display("FAIL mul16_result got %h want ffff", val); end
        checks++; if (flags16 !== 4'b0100) begin errors++; $display("FAIL mul16_flags got %b want 0100", flags16); end
        issue(1, 0, 7, 1, 2, 0, lat, busy, again);
        read_reg(1, 7, val);
        checks++; if (val != 16'h0200) begin errors++; $display("FAIL add16_result got %h want 0200", val); end
        checks++; if (flags16 !== 4'b0000) begin errors++; $display("FAIL add16_flags got %b want 0000", flags16); end
        test_random(1, 20, 5);
    endtask

    task automatic test_reset_mid_mul();
        int lat, busy, seen; bit again; longint val;
        issue(0, 5, 1, 0, 0, 8'h37, lat, busy, again);
        issue(0, 5, 2, 0, 0, 8'h59, lat, busy, again);
        drive(0, 1'b1, 3, 3, 1, 2, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        seen = 0;
        repeat (3) begin seen += int'(if8.done); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++; if (if8.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_ready got %0b want 1", if8.instr_ready); end
        checks++; if (flags8 !== 4'h0) begin errors++; $display("FAIL rst_mul_flags got %b want 0000", flags8); end
        for (int r = 0; r < 4; r++) begin
            read_reg(0, r, val);
            checks++; if (val != 0) begin errors++; $display("FAIL rst_mul_reg%0d got %h want 0", r, val); end
        end
        repeat (12) begin seen += int'(if8.done); @(negedge clk); end
        read_reg(0, 3, val);
        checks++; if (seen != 0 || val != 0) begin errors++; $display("FAIL rst_mul_abort got done=%0d r3=%h want 0 0", seen, val); end
        issue(0, 5, 1, 0, 0, 8'h21, lat, busy, again);
        issue(0, 5, 2, 0, 0, 8'h42, lat, busy, again);
        issue(0, 0, 0, 1, 2, 0, lat, busy, again);
        read_reg(0, 0, val);
        checks++; if (val != 8'h63 || lat != 1) begin errors++; $display("FAIL rst_add got %h lat=%0d want 63 1", val, lat); end
        checks++; if (flags8 !== 4'b0000) begin errors++; $display("FAIL rst_add_flags got %b want 0000", flags8); end
        issue(0, 5, 1, 0, 0, 8'h05, lat, busy, again);
        issue(0, 6, 2, 1, 0, 0, lat, busy, again);
        read_reg(0, 2, val);
        checks++; if (val != m_mem[0][5]) begin errors++; $display("FAIL rst_mem_kept got %h want %h", val, m_mem[0][5]); end
    endtask

    initial begin
        drive(0, 1'b0, 0, 0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0, 0, 0);
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_alu_basic();
        test_back_to_back();
        test_mul();
        test_mem();
        test_random(0, 60, 7);
        test_wide();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
